hero_write_rx: RTL and testbench

HERO_WRITE_RX -- requirements
Module: hero_write_rx

---
 rtl/hero_write_rx.sv | 208 ++++++++++++++++++++
 tb/tb_hero_write_rx.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
// Hero write receiver: buffers speculative beats and exposes them only once the DONE beat commits
// the transaction. Define HERO_WRITE_RX_STATS_EN to enable the saturating commit/drop counters.
module hero_write_rx #(
  parameter int unsigned HERO_WIDTH = 36,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            hero_cycle_type,
  input  logic [HERO_WIDTH-1:0] hero_wdat,
  input  logic                  hero_clk_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HERO_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  err_overflow,
  output logic                  err_protocol,
  output logic                  err_too_long,
  output logic                  busy,
  output logic [15:0]           stat_commit_cnt,
  output logic [15:0]           stat_drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthP    = PW'(DEPTH);
  localparam logic [4:0]    MaxBeatsP = 5'(MAX_BEATS);
  localparam logic [3:0]    CtIdle    = 4'd0;
  localparam logic [3:0]    CtValid   = 4'd1;
  localparam logic [3:0]    CtDone    = 4'd2;

  typedef enum logic [1:0] {StIdle, StActive, StDrop} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rd_q, rd_d, cm_q, cm_d, wr_q, wr_d;
  logic [4:0]    beats_q, beats_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_prot_q, err_prot_d;
  logic          err_long_q, err_long_d;

  logic beat_valid, beat_done, beat_idle, beat_bad;
  logic full, pop, wr_en, wr_last;
  logic commit_evt, drop_evt;

  logic [HERO_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];

  always_comb begin
    beat_valid = hero_clk_en && (hero_cycle_type == CtValid);
    beat_done  = hero_clk_en && (hero_cycle_type == CtDone);
    beat_idle  = hero_clk_en && (hero_cycle_type == CtIdle);
    beat_bad   = hero_clk_en && (hero_cycle_type > CtDone);
    // Occupancy counts speculative entries too and ignores a same-cycle pop.
    full       = (wr_q - rd_q) == DepthP;
    out_valid  = rd_q != cm_q;
    pop        = out_valid && out_ready;
    out_data   = out_valid ? mem_data[rd_q[AW-1:0]] : '0;
    out_last   = out_valid ? mem_last[rd_q[AW-1:0]] : 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    cm_d       = cm_q;
    wr_d       = wr_q;
    beats_d    = beats_q;
    err_ovf_d  = 1'b0;
    err_prot_d = 1'b0;
    err_long_d = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    commit_evt = 1'b0;
    drop_evt   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (beat_bad) begin
          err_prot_d = 1'b1;
        end else if (beat_valid || beat_done) begin
          if (full) begin
            err_ovf_d = 1'b1;
            drop_evt  = 1'b1;
            if (beat_valid) state_d = StDrop;
          end else begin
            wr_en = 1'b1;
            wr_d  = wr_q + 1'b1;
            if (beat_done) begin
              wr_last    = 1'b1;
              cm_d       = wr_q + 1'b1;
              commit_evt = 1'b1;
            end else begin
              state_d = StActive;
              beats_d = 5'd1;
            end
          end
        end
      end
      StActive: begin
        if (beat_bad || beat_idle) begin
          err_prot_d = 1'b1;
          drop_evt   = 1'b1;
          wr_d       = cm_q;
          beats_d    = '0;
          state_d    = StIdle;
        end else if (beat_valid || beat_done) begin
          if (full) begin
            err_ovf_d = 1'b1;
            drop_evt  = 1'b1;
            wr_d      = cm_q;
            beats_d   = '0;
            state_d   = beat_valid ? StDrop : StIdle;
          end else if (beat_valid && (beats_q == MaxBeatsP)) begin
            err_long_d = 1'b1;
            drop_evt   = 1'b1;
            wr_d       = cm_q;
            beats_d    = '0;
            state_d    = StDrop;
          end else begin
            wr_en   = 1'b1;
            wr_d    = wr_q + 1'b1;
            beats_d = beats_q + 1'b1;
            if (beat_done) begin
              wr_last    = 1'b1;
              cm_d       = wr_q + 1'b1;
              commit_evt = 1'b1;
              beats_d    = '0;
              state_d    = StIdle;
            end
          end
        end
      end
      StDrop: begin
        // The drop was already counted when the transaction aborted.
        if (beat_bad) begin
          err_prot_d = 1'b1;
          state_d    = StIdle;
        end else if (beat_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_q       <= '0;
      cm_q       <= '0;
      wr_q       <= '0;
      beats_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_prot_q <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      cm_q       <= cm_d;
      wr_q       <= wr_d;
      beats_q    <= beats_d;
      err_ovf_q  <= err_ovf_d;
      err_prot_q <= err_prot_d;
      err_long_q <= err_long_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_q[AW-1:0]] <= hero_wdat;
      mem_last[wr_q[AW-1:0]] <= wr_last;
    end
  end

  assign err_overflow = err_ovf_q;
  assign err_protocol = err_prot_q;
  assign err_too_long = err_long_q;
  assign busy         = state_q != StIdle;

`ifdef HERO_WRITE_RX_STATS_EN
  logic [15:0] commit_cnt_q, commit_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (commit_evt && (commit_cnt_q != 16'hFFFF)) commit_cnt_d = commit_cnt_q + 16'd1;
    if (drop_evt && (drop_cnt_q != 16'hFFFF))     drop_cnt_d   = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign stat_commit_cnt = commit_cnt_q;
  assign stat_drop_cnt   = drop_cnt_q;
`else
  logic unused_stat_evt;
  assign unused_stat_evt = commit_evt ^ drop_evt;
  assign stat_commit_cnt = '0;
  assign stat_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_hero_write_rx.sv
// Bench for hero_write_rx: directed scenarios plus randomized traffic against a queue-based model.
module tb_hero_write_rx;
  localparam int unsigned W         = 36;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned MAXB      = 16;
  localparam int unsigned BIG_DEPTH = 32;
`ifdef HERO_WRITE_RX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [3:0]   ct = 4'd0;
  logic [W-1:0] wdat = '0;
  logic         rdy = 1'b0;

  logic s_valid, s_last, s_ovf, s_prot, s_long, s_busy;
  logic b_valid, b_last, b_ovf, b_prot, b_long, b_busy;
  logic [W-1:0] s_data, b_data;
  logic [15:0]  s_commit, s_drop, b_commit, b_drop;

  always #5 clk = ~clk;

  hero_write_rx #(.HERO_WIDTH(W), .DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .hero_cycle_type(ct), .hero_wdat(wdat), .hero_clk_en(en),
    .out_valid(s_valid), .out_ready(rdy), .out_data(s_data), .out_last(s_last),
    .err_overflow(s_ovf), .err_protocol(s_prot), .err_too_long(s_long), .busy(s_busy),
    .stat_commit_cnt(s_commit), .stat_drop_cnt(s_drop)
  );

  // Deeper instance so a too-long transaction is reachable before the buffer fills.
  hero_write_rx #(.HERO_WIDTH(W), .DEPTH(BIG_DEPTH), .MAX_BEATS(MAXB)) dut_big (
    .clk(clk), .rst_n(rst_n), .hero_cycle_type(ct), .hero_wdat(wdat), .hero_clk_en(en),
    .out_valid(b_valid), .out_ready(rdy), .out_data(b_data), .out_last(b_last),
    .err_overflow(b_ovf), .err_protocol(b_prot), .err_too_long(b_long), .busy(b_busy),
    .stat_commit_cnt(b_commit), .stat_drop_cnt(b_drop)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } ent_t;

  // Reference model of the DEPTH=8 instance: committed and pending beats as queues.
  ent_t cq[$];
  ent_t sq[$];
  int   mode;
  bit   e_ovf, e_prot, e_long;
  int   n_commit, n_drop, beats;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic model_reset();
    cq.delete();
    sq.delete();
    mode = 0;
    e_ovf = 0; e_prot = 0; e_long = 0;
    n_commit = 0; n_drop = 0; beats = 0;
  endtask

  task automatic model_step(input logic m_en, input logic [3:0] m_ct, input logic [W-1:0] m_d,
                            input logic m_rdy);
    bit   v, dn, bad, idl, full;
    ent_t nc[$];
    ent_t e;
    v    = m_en && (m_ct == 4'd1);
    dn   = m_en && (m_ct == 4'd2);
    bad  = m_en && (m_ct > 4'd2);
    idl  = m_en && (m_ct == 4'd0);
    full = (cq.size() + sq.size()) >= DEPTH;
    e_ovf = 0; e_prot = 0; e_long = 0;
    e.d = m_d;
    e.l = dn;
    case (mode)
      0: begin
        if (bad) e_prot = 1;
        else if (v || dn) begin
          if (full) begin
            e_ovf = 1; n_drop++;
            if (v) mode = 2;
          end else if (dn) begin
            nc.push_back(e); n_commit++;
          end else begin
            sq.push_back(e); beats = 1; mode = 1;
          end
        end
      end
      1: begin
        if (bad || idl) begin
          e_prot = 1; n_drop++; sq.delete(); mode = 0;
        end else if (v || dn) begin
          if (full) begin
            e_ovf = 1; n_drop++; sq.delete(); mode = v ? 2 : 0;
          end else if (v && beats == MAXB) begin
            e_long = 1; n_drop++; sq.delete(); mode = 2;
          end else begin
            sq.push_back(e); beats++;
            if (dn) begin
              nc = sq; sq.delete(); n_commit++; mode = 0;
            end
          end
        end
      end
      default: begin
        if (bad) begin
          e_prot = 1; mode = 0;
        end else if (dn) mode = 0;
      end
    endcase
    if (m_rdy && cq.size() > 0) void'(cq.pop_front());
    foreach (nc[i]) cq.push_back(nc[i]);
  endtask

  task automatic drive(input logic d_en, input logic [3:0] d_ct, input logic [W-1:0] d_d,
                       input logic d_rdy);
    @(negedge clk);
    en = d_en; ct = d_ct; wdat = d_d; rdy = d_rdy;
    @(posedge clk);
    model_step(d_en, d_ct, d_d, d_rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; ct = 4'd0; wdat = '0; rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({s_valid, s_last, s_ovf, s_prot, s_long, s_busy} !== 6'b0 || s_data !== '0) begin
      n_fail++;
      $display("FAIL reset_small: flags=%b data=%h, required 0", 
               {s_valid, s_last, s_ovf, s_prot, s_long, s_busy}, s_data);
    end
    n_checks++;
    if ({b_valid, b_last, b_ovf, b_prot, b_long, b_busy} !== 6'b0 || b_data !== '0) begin
      n_fail++;
      $display("FAIL reset_big: flags=%b data=%h, required 0",
               {b_valid, b_last, b_ovf, b_prot, b_long, b_busy}, b_data);
    end
    n_checks++;
    if (s_commit !== 16'd0 || s_drop !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: commit=%0d drop=%0d, required 0", s_commit, s_drop);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_d;
    do_reset();
    drive(1'b1, 4'd1, 36'h1, 1'b1);
    drive(1'b1, 4'd1, 36'h2, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %b, required 0", s_valid);
    end
    drive(1'b1, 4'd2, 36'h3, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      exp_d = W'(i);
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp_d || s_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                 i, s_valid, s_data, s_last, exp_d, (i == 3));
      end
      drive(1'b0, 4'd0, '0, 1'b1);
    end
    n_checks++;
    if (s_valid !== 1'b0 || s_data !== '0) begin
      n_fail++; $display("FAIL basic_drained: valid=%b data=%h, required 0 0", s_valid, s_data);
    end
  endtask

  task automatic test_single_done();
    do_reset();
    drive(1'b1, 4'd2, 36'hA, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 36'hA || s_last !== 1'b1 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: valid=%b data=%h last=%b busy=%b, required 1 a 1 0",
               s_valid, s_data, s_last, s_busy);
    end
    drive(1'b0, 4'd0, '0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: valid=%b busy=%b, required 0 0", s_valid, s_busy);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'd1, W'(32'h10 + i), 1'b0);
    drive(1'b1, 4'd2, 36'h15, 1'b0);
    drive(1'b1, 4'd1, 36'h20, 1'b0);
    drive(1'b1, 4'd1, 36'h21, 1'b0);
    n_checks++;
    if (s_ovf !== 1'b0 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_early: ovf=%b busy=%b, required 0 1", s_ovf, s_busy);
    end
    drive(1'b1, 4'd1, 36'h22, 1'b0);
    n_checks++;
    if (s_ovf !== 1'b1 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse: ovf=%b busy=%b, required 1 1", s_ovf, s_busy);
    end
    drive(1'b1, 4'd1, 36'h23, 1'b0);
    drive(1'b1, 4'd2, 36'h24, 1'b0);
    n_checks++;
    if (s_ovf !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL ovf_recover: ovf=%b busy=%b, required 0 0", s_ovf, s_busy);
    end
    n_checks++;
    if (s_drop !== (StatsEn ? 16'd1 : 16'd0) || s_commit !== (StatsEn ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL ovf_stats: drop=%0d commit=%0d, required %0d %0d",
               s_drop, s_commit, StatsEn, StatsEn);
    end
    for (int i = 0; i < 6; i++) begin
      exp_d = W'(32'h10 + i);
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp_d || s_last !== (i == 5)) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: valid=%b data=%h last=%b, required 1 %h %b",
                 i, s_valid, s_data, s_last, exp_d, (i == 5));
      end
      drive(1'b0, 4'd0, '0, 1'b1);
    end
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_extra_beat: valid=%b data=%h, required 0", s_valid, s_data);
    end
  endtask

  task automatic test_too_long();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 4'd1, W'(i), 1'b0);
      n_checks++;
      if (b_long !== (i == 17) || b_busy !== 1'b1 || b_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL too_long_beat%0d: long=%b busy=%b valid=%b, required %b 1 0",
                 i, b_long, b_busy, b_valid, (i == 17));
      end
    end
    drive(1'b1, 4'd2, 36'h99, 1'b0);
    n_checks++;
    if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_long !== 1'b0) begin
      n_fail++;
      $display("FAIL too_long_done: busy=%b valid=%b long=%b, required 0 0 0",
               b_busy, b_valid, b_long);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    drive(1'b1, 4'd1, 36'h7, 1'b1);
    drive(1'b1, 4'd1, 36'h8, 1'b1);
    drive(1'b1, 4'd0, 36'h0, 1'b1);
    n_checks++;
    if (s_prot !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL protocol_pulse: prot=%b busy=%b valid=%b, required 1 0 0",
               s_prot, s_busy, s_valid);
    end
    drive(1'b1, 4'd2, 36'h5, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 36'h5 || s_last !== 1'b1 || s_prot !== 1'b0) begin
      n_fail++;
      $display("FAIL protocol_next: valid=%b data=%h last=%b prot=%b, required 1 5 1 0",
               s_valid, s_data, s_last, s_prot);
    end
    drive(1'b0, 4'd0, '0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL protocol_alone: valid=%b data=%h, required 0", s_valid, s_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 4'd2, 36'h9, 1'b0);
    drive(1'b1, 4'd1, 36'h1, 1'b0);
    drive(1'b1, 4'd1, 36'h2, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pending: valid=%b busy=%b, required 1 1", s_valid, s_busy);
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_valid !== 1'b0 || s_data !== '0 || s_last !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: valid=%b data=%h last=%b busy=%b, required 0 0 0 0",
               s_valid, s_data, s_last, s_busy);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, '0, 1'b1);
      n_checks++;
      if (s_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_ghost%0d: valid=%b data=%h, required 0", i, s_valid, s_data);
      end
    end
    drive(1'b1, 4'd2, 36'hB, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 36'hB || s_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_fresh: valid=%b data=%h last=%b, required 1 b 1",
               s_valid, s_data, s_last);
    end
  endtask

  task automatic test_random();
    logic [3:0]   r_ct;
    logic [W-1:0] r_d, exp_d;
    logic         exp_v, exp_l;
    int           sel;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 55) r_ct = 4'd1;
      else if (sel < 78) r_ct = 4'd2;
      else if (sel < 92) r_ct = 4'd0;
      else r_ct = 4'($urandom_range(3, 15));
      r_d = {4'($urandom), 32'($urandom)};
      drive(($urandom_range(0, 9) < 8), r_ct, r_d, $urandom_range(0, 1) == 1);
      exp_v = cq.size() > 0;
      exp_d = exp_v ? cq[0].d : '0;
      exp_l = exp_v ? cq[0].l : 1'b0;
      n_checks++;
      if ({s_valid, s_last, s_ovf, s_prot, s_long, s_busy} !==
          {exp_v, exp_l, e_ovf, e_prot, e_long, (mode != 0)}) begin
        n_fail++;
        $display("FAIL rand_flags cyc%0d: v/l/ovf/prot/long/busy=%b, required %b", cyc,
                 {s_valid, s_last, s_ovf, s_prot, s_long, s_busy},
                 {exp_v, exp_l, e_ovf, e_prot, e_long, (mode != 0)});
      end
      n_checks++;
      if (s_data !== exp_d) begin
        n_fail++; $display("FAIL rand_data cyc%0d: got %h, required %h", cyc, s_data, exp_d);
      end
      n_checks++;
      if (s_commit !== (StatsEn ? 16'(n_commit) : 16'd0) ||
          s_drop !== (StatsEn ? 16'(n_drop) : 16'd0)) begin
        n_fail++;
        $display("FAIL rand_stats cyc%0d: commit=%0d drop=%0d, required %0d %0d", cyc,
                 s_commit, s_drop, StatsEn ? n_commit : 0, StatsEn ? n_drop : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_done();
    test_overflow();
    test_too_long();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
